roi_patch_extractor: RTL and testbench

- Upstream producer for the per-site 3x3 Gaussian classifier.
- Takes the raster pixel stream from the FMC camera path, keeps two line buffers and a 3x3 sliding window, and emits one packed 72-bit patch plus a site ID for each atom site on a fixed rectangular grid.
- The output bundle drives the classifier's roi_data/valid/base_id inputs directly; there is no backpressure.

---
 rtl/roi_patch_extractor_if.sv | 34 +++
 rtl/roi_patch_extractor.sv | 219 +++++++++++++++++++++
 tb/tb_roi_patch_extractor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/roi_patch_extractor_if.sv
// ============================================================================
//  Module      : roi_patch_extractor_if
//  Description : Pixel-stream input and patch/status output bundle for
//                roi_patch_extractor. The slave modport is the extractor side;
//                the master modport is the camera/classifier side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface roi_patch_extractor_if;
    // Raster pixel stream from the camera path
    logic [7:0]  i_pix;
    logic        i_pix_valid;
    logic        i_sof;
    // Patch bundle towards the classifier, plus status
    logic [71:0] o_roi_data;
    logic        o_valid;
    logic [6:0]  o_base_id;
    logic        o_frame_done;
    logic        o_sof_err;
    logic        o_busy;

    modport slave (
        input  i_pix, i_pix_valid, i_sof,
        output o_roi_data, o_valid, o_base_id, o_frame_done, o_sof_err, o_busy
    );

    modport master (
        output i_pix, i_pix_valid, i_sof,
        input  o_roi_data, o_valid, o_base_id, o_frame_done, o_sof_err, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/roi_patch_extractor.sv
// ============================================================================
//  Module      : roi_patch_extractor
//  Description : Two line buffers plus a 3x3 sliding window over a raster
//                pixel stream; emits one packed 72-bit patch and a site ID
//                for every site of a fixed rectangular grid.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module roi_patch_extractor #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int GRID_X0 = 4,
    parameter int GRID_Y0 = 4,
    parameter int PITCH   = 6,
    parameter int N_COLS  = 10,
    parameter int N_ROWS  = 10
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    roi_patch_extractor_if.slave bus
);

    localparam int XW = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
    localparam int YW = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    localparam logic [XW-1:0] c_X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] c_Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] c_SITE_X0 = XW'(GRID_X0 + 1);
    localparam logic [YW-1:0] c_SITE_Y0 = YW'(GRID_Y0 + 1);
    localparam logic [CW-1:0] c_COL_LAST = CW'(N_COLS - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(N_ROWS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    // Raster position of the next expected pixel
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;

    // Next-site trigger position (xc+1, yc+1) and grid bookkeeping
    logic [XW-1:0]  r_site_x;
    logic [YW-1:0]  r_site_y;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [6:0]     r_id;
    logic           r_sites_done;

    // Line buffers: r_lb1 holds line y-1, r_lb2 holds line y-2
    logic [7:0]     r_lb1 [IMG_W];
    logic [7:0]     r_lb2 [IMG_W];

    // Window columns {row0 = current line, row1 = y-1, row2 = y-2};
    // r_c1 is column x-1, r_c2 is column x-2 relative to the incoming pixel
    logic [23:0]    r_c1;
    logic [23:0]    r_c2;

    logic [71:0]    r_roi_data;
    logic           r_valid;
    logic [6:0]     r_base_id;
    logic           r_frame_done;
    logic           r_sof_err;

    logic           w_take;
    logic           w_restart;
    logic           w_sof_err;
    logic           w_last;
    logic           w_hit;
    logic [XW-1:0]  w_px;
    logic [YW-1:0]  w_py;
    logic [7:0]     w_lb1;
    logic [7:0]     w_lb2;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-pixel decode: which pixel is accepted and where it sits
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_restart   = 1'b0;
        w_sof_err   = 1'b0;
        w_last      = 1'b0;
        w_px        = r_x;
        w_py        = r_y;
        if (bus.i_pix_valid) begin
            if (bus.i_sof) begin
                // SOF always starts a fresh frame at (0,0), even mid-frame
                w_take      = 1'b1;
                w_restart   = 1'b1;
                w_px        = '0;
                w_py        = '0;
                w_sof_err   = (r_state == S_FRAME);
                w_state_nxt = S_FRAME;
            end else if (r_state == S_FRAME) begin
                w_take = 1'b1;
                if (r_x == c_X_LAST && r_y == c_Y_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    // A site fires when its lower-right neighbour pixel arrives
    assign w_hit = w_take && !w_restart && !r_sites_done &&
                   (r_x == r_site_x) && (r_y == r_site_y);

    assign w_lb1 = r_lb1[w_px];
    assign w_lb2 = r_lb2[w_px];

    // Line buffers shift down one line at this column; contents survive reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_take) begin
            r_lb1[w_px] <= bus.i_pix;
            r_lb2[w_px] <= w_lb1;
        end
    end

    // 3x3 window column shift, only on accepted pixels
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c1 <= '0;
            r_c2 <= '0;
        end else if (w_take) begin
            r_c1 <= {bus.i_pix, w_lb1, w_lb2};
            r_c2 <= r_c1;
        end
    end

    // Raster counters and incremental next-site tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_site_x     <= '0;
            r_site_y     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_id         <= '0;
            r_sites_done <= 1'b0;
        end else if (w_take) begin
            if (w_px == c_X_LAST) begin
                r_x <= '0;
                r_y <= w_py + 1'b1;
            end else begin
                r_x <= w_px + 1'b1;
                r_y <= w_py;
            end

            if (w_restart) begin
                r_site_x     <= c_SITE_X0;
                r_site_y     <= c_SITE_Y0;
                r_col        <= '0;
                r_row        <= '0;
                r_id         <= '0;
                r_sites_done <= 1'b0;
            end else if (w_hit) begin
                r_id <= r_id + 7'd1;
                if (r_col == c_COL_LAST) begin
                    r_col    <= '0;
                    r_site_x <= c_SITE_X0;
                    r_row    <= r_row + 1'b1;
                    r_site_y <= r_site_y + YW'(PITCH);
                    if (r_row == c_ROW_LAST) begin
                        r_sites_done <= 1'b1;
                    end
                end else begin
                    r_col    <= r_col + 1'b1;
                    r_site_x <= r_site_x + XW'(PITCH);
                end
            end
        end
    end

    // Registered output bundle; patch and ID hold between strobes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_roi_data   <= '0;
            r_valid      <= 1'b0;
            r_base_id    <= '0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_valid      <= w_hit;
            r_frame_done <= w_last;
            r_sof_err    <= w_sof_err;
            if (w_hit) begin
                r_roi_data <= {r_c2[23:16], r_c1[23:16], bus.i_pix,
                               r_c2[15:8],  r_c1[15:8],  w_lb1,
                               r_c2[7:0],   r_c1[7:0],   w_lb2};
                r_base_id  <= r_id;
            end
        end
    end

    assign bus.o_roi_data   = r_roi_data;
    assign bus.o_valid      = r_valid;
    assign bus.o_base_id    = r_base_id;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_sof_err    = r_sof_err;
    assign bus.o_busy       = (r_state == S_FRAME);

endmodule

`default_nettype wire

// File: tb/tb_roi_patch_extractor.sv
// ============================================================================
//  Module      : tb_roi_patch_extractor
//  Description : Directed self-checking bench for roi_patch_extractor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_roi_patch_extractor;

    localparam int W   = 64;
    localparam int H   = 64;
    localparam int GX0 = 4;
    localparam int GY0 = 4;
    localparam int P   = 6;
    localparam int NC  = 10;
    localparam int NR  = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    roi_patch_extractor_if bus ();

    roi_patch_extractor #(
        .IMG_W  (W),
        .IMG_H  (H),
        .GRID_X0(GX0),
        .GRID_Y0(GY0),
        .PITCH  (P),
        .N_COLS (NC),
        .N_ROWS (NR)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          mode   = 0;     // 0: ramp frame, 1: constant 8'hFF
    bit          e_busy;
    bit          p_valid;
    bit          p_done;
    bit          p_err;
    logic [71:0] e_data;
    logic [6:0]  e_id;
    int          v_cnt;
    int          last_id;
    bit          want_first;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] pixf(input int x, input int y);
        if (mode != 0) return 8'hFF;
        return 8'((y * W + x) % 256);
    endfunction

    function automatic logic [71:0] patch(input int xc, input int yc);
        return {pixf(xc-1, yc+1), pixf(xc, yc+1), pixf(xc+1, yc+1),
                pixf(xc-1, yc),   pixf(xc, yc),   pixf(xc+1, yc),
                pixf(xc-1, yc-1), pixf(xc, yc-1), pixf(xc+1, yc-1)};
    endfunction

    // Compare DUT outputs (registered at the last posedge) with expectations
    task automatic observe();
        chk("valid",      {71'd0, bus.o_valid},      {71'd0, p_valid});
        chk("frame_done", {71'd0, bus.o_frame_done}, {71'd0, p_done});
        chk("sof_err",    {71'd0, bus.o_sof_err},    {71'd0, p_err});
        chk("busy",       {71'd0, bus.o_busy},       {71'd0, e_busy});
        chk("roi_data",   bus.o_roi_data,            e_data);
        chk("base_id",    {65'd0, bus.o_base_id},    {65'd0, e_id});
        if (bus.o_valid) begin
            if (want_first) begin
                chk("first_patch", bus.o_roi_data, 72'h43_44_45_03_04_05_C3_C4_C5);
                chk("first_id", {65'd0, bus.o_base_id}, 72'd0);
                want_first = 1'b0;
            end
            v_cnt++;
            last_id = int'(bus.o_base_id);
        end
    endtask

    // One clock: check the previous cycle, then drive pixel (x,y)
    task automatic step(input bit v, input bit s, input int x, input int y);
        bit live;
        int dx;
        int dy;
        @(negedge clk);
        observe();
        live    = v && (s || e_busy);
        p_err   = v && s && e_busy;
        p_valid = 1'b0;
        p_done  = 1'b0;
        if (live && !s) begin
            dx = x - GX0 - 1;
            dy = y - GY0 - 1;
            if (dx >= 0 && dy >= 0 && dx % P == 0 && dy % P == 0 &&
                dx / P < NC && dy / P < NR) begin
                p_valid = 1'b1;
                e_id    = 7'((dy / P) * NC + dx / P);
                e_data  = patch(x - 1, y - 1);
            end
            if (x == W - 1 && y == H - 1) begin
                p_done = 1'b1;
                e_busy = 1'b0;
            end
        end
        if (v && s) e_busy = 1'b1;
        rst             = 1'b0;
        bus.i_pix_valid = v;
        bus.i_sof       = s;
        bus.i_pix       = v ? pixf(x, y) : 8'($urandom);
    endtask

    // Flat pixel indices from..to of a frame, optional random gaps (percent)
    task automatic run(input int from, input int to, input int gap);
        for (int k = from; k <= to; k++) begin
            if (gap > 0) begin
                while (int'($urandom_range(99)) < gap) step(1'b0, 1'b0, 0, 0);
            end
            step(1'b1, (k == 0), k % W, k / W);
        end
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic rst_pulse(input int x, input int y);
        @(negedge clk);
        observe();
        rst             = 1'b1;
        bus.i_pix_valid = 1'b1;
        bus.i_sof       = 1'b0;
        bus.i_pix       = pixf(x, y);
        p_valid = 1'b0;
        p_done  = 1'b0;
        p_err   = 1'b0;
        e_busy  = 1'b0;
        e_data  = '0;
        e_id    = '0;
    endtask

    task automatic frame_counts(input string tag);
        chk({tag, "_nvalid"},  72'(v_cnt),   72'd100);
        chk({tag, "_last_id"}, 72'(last_id), 72'd99);
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_pix       = 8'd0;
        bus.i_pix_valid = 1'b0;
        bus.i_sof       = 1'b0;
        e_busy  = 1'b0;
        p_valid = 1'b0;
        p_done  = 1'b0;
        p_err   = 1'b0;
        e_data  = '0;
        e_id    = '0;
        v_cnt   = 0;
        last_id = -1;
        want_first = 1'b0;
        repeat (3) @(negedge clk);
        observe();                               // reset state

        // Pixels before any SOF are dropped
        for (int k = 0; k < 200; k++) step(1'b1, 1'b0, k % W, k / W);

        // Plain ramp frame
        v_cnt = 0; want_first = 1'b1;
        run(0, W * H - 1, 0);
        flush(4);
        frame_counts("ramp");

        // Ramp with ~40% valid gaps
        v_cnt = 0;
        run(0, W * H - 1, 40);
        flush(4);
        frame_counts("gaps");

        // SOF reasserted at (10,20): new frame starts there
        run(0, 20 * W + 10 - 1, 0);
        v_cnt = 0;
        run(0, W * H - 1, 0);
        flush(4);
        frame_counts("restart");

        // Reset at (30,30), stray pixels ignored, then a clean frame
        run(0, 30 * W + 30 - 1, 0);
        rst_pulse(30, 30);
        for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 31 + (k % 32), 30);
        v_cnt = 0;
        run(0, W * H - 1, 0);
        flush(4);
        frame_counts("post_rst");

        // Constant 8'hFF frame
        mode  = 1;
        v_cnt = 0;
        run(0, W * H - 1, 0);
        flush(4);
        frame_counts("const");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
